fwd_scoreboard: RTL and testbench

Parametrised operand-forwarding and hazard scoreboard for the integer pipeline, covering operand bypass and load-use stall detection. It keeps a shift register of in-flight destination writes, one entry per stage from EX onward, each with a remaining-latency counter. Each cycle it checks the ID-stage source registers against that history and produces two things: a combinational stall, and registered per-source forward selects that drive the EX-stage operand muxes. It supports any number of source operands, pipeline depth and result latency, which covers multi-cycle loads and multiplies.

---
 rtl/fwd_scoreboard_pkg.sv | 30 +++
 rtl/fwd_scoreboard_if.sv | 29 ++
 rtl/fwd_scoreboard_match.sv | 31 +++
 rtl/fwd_scoreboard.sv | 78 +++++++
 tb/tb_fwd_scoreboard.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and constants for the operand-forwarding scoreboard.
// The entry struct uses fixed maximum widths so one type serves every parameterisation.
package fwd_pkg;

  localparam int REG_MAX_W = 8;
  localparam int CNT_MAX_W = 4;

  localparam int FWD_RF  = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  typedef struct packed {
    logic                 valid;
    logic [REG_MAX_W-1:0] rd;
    logic [CNT_MAX_W-1:0] cnt;
  } fwd_entry_t;

  // Remaining latency after entering EX: min(max(lat,1), depth) - 1.
  function automatic logic [CNT_MAX_W-1:0] lat_to_cnt(input int unsigned lat,
                                                      input int unsigned depth);
    int unsigned eff;
    eff = (lat == 0) ? LAT_ALU : lat;
    if (eff > depth) eff = depth;
    return CNT_MAX_W'(eff - 1);
  endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// ID-stage request and EX-side forward-select bundle of the scoreboard.
// master = pipeline control driving ID information, slave = the scoreboard.
interface fwd_scoreboard_if #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int REG_W   = 5,
  parameter int LAT_W   = 2,
  parameter int SEL_W   = $clog2(DEPTH + 1)
);
  logic [NUM_SRC*REG_W-1:0] iID_NumSrc;
  logic [NUM_SRC-1:0]       iID_SrcUsed;
  logic [REG_W-1:0]         iID_NumRd;
  logic                     iID_RegWrite;
  logic [LAT_W-1:0]         iID_Lat;
  logic                     iHold;
  logic                     iFlush;
  logic                     oStall;
  logic [NUM_SRC*SEL_W-1:0] oFwdSel;

  modport master (
    output iID_NumSrc, iID_SrcUsed, iID_NumRd, iID_RegWrite, iID_Lat, iHold, iFlush,
    input  oStall, oFwdSel
  );

  modport slave (
    input  iID_NumSrc, iID_SrcUsed, iID_NumRd, iID_RegWrite, iID_Lat, iHold, iFlush,
    output oStall, oFwdSel
  );
endinterface

// File: rtl/fwd_scoreboard_match.sv
// Priority matcher for one source operand against the in-flight write history.
// The youngest matching entry (lowest index) wins.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int IDX_W = 2
) (
  input  logic                   used_i,
  input  logic [REG_MAX_W-1:0]   src_i,
  input  fwd_entry_t [DEPTH-1:0] entries_i,
  output logic                   hit_o,
  output logic                   ready_o,
  output logic [IDX_W-1:0]       index_o
);

  always_comb begin
    hit_o   = 1'b0;
    ready_o = 1'b0;
    index_o = '0;
    // Scan oldest to youngest so the youngest match overwrites older ones.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (used_i && (src_i != '0) && entries_i[k].valid && (entries_i[k].rd == src_i)) begin
        hit_o   = 1'b1;
        ready_o = (entries_i[k].cnt == '0);
        index_o = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand-forwarding and load-use hazard scoreboard: tracks in-flight writes from EX
// onward, raises a combinational stall and registers per-source forward selects for EX.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int REG_W   = 5,
  parameter int LAT_W   = 2,
  parameter int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic             iCLK,
  input  logic             iRST,
  fwd_scoreboard_if.slave  bus
);

  fwd_entry_t [DEPTH-1:0]   entries_q;
  fwd_entry_t               entry0_d;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_q;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_d;
  logic [NUM_SRC-1:0]       not_ready;
  logic                     stall;
  logic                     squash;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic             hit;
      logic             ready;
      logic [SEL_W-1:0] idx;

      fwd_match #(
        .DEPTH (DEPTH),
        .IDX_W (SEL_W)
      ) u_match (
        .used_i    (bus.iID_SrcUsed[gi]),
        .src_i     (REG_MAX_W'(bus.iID_NumSrc[gi*REG_W +: REG_W])),
        .entries_i (entries_q),
        .hit_o     (hit),
        .ready_o   (ready),
        .index_o   (idx)
      );

      assign not_ready[gi] = hit & ~ready;
      // Entry k sits on forward bus k+1 (entry 0 -> MEM bus).
      assign fwd_sel_d[gi*SEL_W +: SEL_W] = (hit & ready) ? idx + SEL_W'(FWD_MEM)
                                                          : SEL_W'(FWD_RF);
    end
  endgenerate

  assign stall       = (|not_ready) & ~bus.iHold;
  assign squash      = stall | bus.iFlush;
  assign bus.oStall  = stall;
  assign bus.oFwdSel = fwd_sel_q;

  always_comb begin
    entry0_d       = '0;
    entry0_d.valid = bus.iID_RegWrite & (bus.iID_NumRd != '0);
    entry0_d.rd    = REG_MAX_W'(bus.iID_NumRd);
    entry0_d.cnt   = lat_to_cnt(32'(bus.iID_Lat), DEPTH);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      entries_q <= '0;
      fwd_sel_q <= '0;
    end else if (!bus.iHold) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        entries_q[k].valid <= entries_q[k-1].valid;
        entries_q[k].rd    <= entries_q[k-1].rd;
        entries_q[k].cnt   <= (entries_q[k-1].cnt == '0) ? '0 : entries_q[k-1].cnt - 1'b1;
      end
      // A stalled or flushed ID instruction enters EX as a bubble.
      entries_q[0] <= squash ? '0 : entry0_d;
      fwd_sel_q    <= squash ? '0 : fwd_sel_d;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench: directed hazard scenarios plus random traffic against a
// time-stamped producer-list model; a second instance covers DEPTH=4, NUM_SRC=3.
module tb_fwd_scoreboard;
  import fwd_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fwd_scoreboard_if #(.NUM_SRC(2), .DEPTH(3), .REG_W(5), .LAT_W(2)) b3 ();
  fwd_scoreboard_if #(.NUM_SRC(3), .DEPTH(4), .REG_W(5), .LAT_W(3)) b4 ();

  fwd_scoreboard #(.NUM_SRC(2), .DEPTH(3), .REG_W(5), .LAT_W(2)) dut3 (
    .iCLK (clk), .iRST (rst), .bus (b3)
  );
  fwd_scoreboard #(.NUM_SRC(3), .DEPTH(4), .REG_W(5), .LAT_W(3)) dut4 (
    .iCLK (clk), .iRST (rst), .bus (b4)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: every producer that entered EX, stamped with the cycle it did so.
  typedef struct {
    int rd;
    int lat;
    int t;
  } prod_t;
  prod_t     hist[$];
  int        now_t;
  logic [3:0] exp_sel_q;

  logic       obs_stall, exp_stall;
  logic [3:0] obs_sel, exp_sel, nsel;
  logic       obs4_stall;
  logic [8:0] obs4_sel;

  function automatic void model_clear();
    hist.delete();
    now_t     = 0;
    exp_sel_q = '0;
  endfunction

  function automatic void model_eval(input logic [9:0] srcs, input logic [1:0] used,
                                     input logic hold, output logic stall,
                                     output logic [3:0] sel);
    logic nr;
    nr  = 1'b0;
    sel = '0;
    for (int s = 0; s < 2; s++) begin
      int src, best_t, best_age, age;
      logic rdy;
      src    = int'(srcs[s*5 +: 5]);
      best_t = -1; best_age = 0; rdy = 1'b0;
      if (used[s] && src != 0) begin
        foreach (hist[i]) begin
          age = now_t - hist[i].t;
          if (age < 3 && hist[i].rd == src && hist[i].t > best_t) begin
            best_t   = hist[i].t;
            best_age = age;
            rdy      = (age >= hist[i].lat - 1);
          end
        end
      end
      if (best_t >= 0) begin
        if (!rdy) nr = 1'b1;
        else      sel[s*2 +: 2] = 2'(best_age + 1);
      end
    end
    stall = nr && !hold;
  endfunction

  function automatic void model_edge(input logic [4:0] rd, input logic rw, input logic [1:0] lat,
                                     input logic hold, input logic flush, input logic stall,
                                     input logic [3:0] sel);
    int eff;
    if (hold) return;
    now_t++;
    if (!(stall || flush)) begin
      eff = (lat == 0) ? 1 : ((int'(lat) > 3) ? 3 : int'(lat));
      if (rw && rd != 0) hist.push_back('{int'(rd), eff, now_t});
      exp_sel_q = sel;
    end else begin
      exp_sel_q = '0;
    end
    while (hist.size() > 0 && now_t - hist[0].t >= 3) void'(hist.pop_front());
  endfunction

  task automatic do_reset(input logic hold_during);
    rst      = 1'b1;
    b3.iHold = hold_during;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    b3.iHold = 1'b0;
    model_clear();
  endtask

  // One ID cycle on the DEPTH=3 instance; starts and ends 1 time unit after a rising edge.
  task automatic tick(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                      input logic [4:0] rd, input logic rw, input logic [1:0] lat,
                      input logic hold, input logic flush);
    b3.iID_NumSrc   = {s1, s0};
    b3.iID_SrcUsed  = used;
    b3.iID_NumRd    = rd;
    b3.iID_RegWrite = rw;
    b3.iID_Lat      = lat;
    b3.iHold        = hold;
    b3.iFlush       = flush;
    #3;
    obs_stall = b3.oStall;
    model_eval({s1, s0}, used, hold, exp_stall, nsel);
    @(posedge clk);
    model_edge(rd, rw, lat, hold, flush, exp_stall, nsel);
    #1;
    obs_sel = b3.oFwdSel;
    exp_sel = exp_sel_q;
    $display("txn src=%0d,%0d used=%b rd=%0d rw=%b lat=%0d hold=%b flush=%b stall=%b sel=%h",
             s0, s1, used, rd, rw, lat, hold, flush, obs_stall, obs_sel);
  endtask

  task automatic tick4(input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [2:0] used, input logic [4:0] rd, input logic rw,
                       input logic [2:0] lat);
    b4.iID_NumSrc   = {s2, s1, s0};
    b4.iID_SrcUsed  = used;
    b4.iID_NumRd    = rd;
    b4.iID_RegWrite = rw;
    b4.iID_Lat      = lat;
    b4.iHold        = 1'b0;
    b4.iFlush       = 1'b0;
    #3;
    obs4_stall = b4.oStall;
    @(posedge clk);
    #1;
    obs4_sel = b4.oFwdSel;
    $display("txn4 src=%0d,%0d,%0d used=%b rd=%0d rw=%b lat=%0d stall=%b sel=%h",
             s0, s1, s2, used, rd, rw, lat, obs4_stall, obs4_sel);
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    b3.iID_NumSrc  = {5'd5, 5'd5};
    b3.iID_SrcUsed = 2'b11;
    #3;
    checks++;
    if (b3.oStall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", b3.oStall); end
    checks++;
    if (b3.oFwdSel !== 4'h0) begin errors++; $display("FAIL reset_sel got=%h want=0", b3.oFwdSel); end
    @(posedge clk); #1;
    // Mid-operation reset, asserted together with iHold, discards the pending load.
    tick(5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 2'(LAT_LOAD), 1'b0, 1'b0);
    do_reset(1'b1);
    checks++;
    if (b3.oFwdSel !== 4'h0) begin errors++; $display("FAIL reset_hold_sel got=%h want=0", b3.oFwdSel); end
    tick(5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 2'd1, 1'b0, 1'b0);
    checks++;
    if (obs_stall !== 1'b0) begin errors++; $display("FAIL reset_history_stall got=%b want=0", obs_stall); end
    checks++;
    if (obs_sel !== 4'h0) begin errors++; $display("FAIL reset_history_sel got=%h want=0", obs_sel); end
  endtask

  task automatic test_alu_use();
    tick(5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 2'(LAT_ALU), 1'b0, 1'b0);
    tick(5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 2'd1, 1'b0, 1'b0);
    checks++;
    if (obs_stall !== 1'b0) begin errors++; $display("FAIL alu_stall got=%b want=0", obs_stall); end
    checks++;
    if (obs_sel !== 4'h1) begin errors++; $display("FAIL alu_sel got=%h want=1", obs_sel); end
  endtask

  task automatic test_load_use();
    tick(5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 2'(LAT_LOAD), 1'b0, 1'b0);
    tick(5'd4, 5'd0, 2'b01, 5'd6, 1'b1, 2'd1, 1'b0, 1'b0);
    checks++;
    if (obs_stall !== 1'b1) begin errors++; $display("FAIL load_stall1 got=%b want=1", obs_stall); end
    checks++;
    if (obs_sel !== 4'h0) begin errors++; $display("FAIL load_bubble_sel got=%h want=0", obs_sel); end
    tick(5'd4, 5'd0, 2'b01, 5'd6, 1'b1, 2'd1, 1'b0, 1'b0);
    checks++;
    if (obs_stall !== 1'b0) begin errors++; $display("FAIL load_stall2 got=%b want=0", obs_stall); end
    checks++;
    if (obs_sel !== 4'(FWD_WB)) begin errors++; $display("FAIL load_sel got=%h want=2", obs_sel); end
  endtask

  task automatic test_priority();
    tick(5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2'd1, 1'b0, 1'b0);
    tick(5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2'd1, 1'b0, 1'b0);
    tick(5'd0, 5'd7, 2'b10, 5'd0, 1'b0, 2'd1, 1'b0, 1'b0);
    checks++;
    if (obs_sel !== 4'h4) begin errors++; $display("FAIL prio_sel got=%h want=4", obs_sel); end
    tick(5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 2'(LAT_LOAD), 1'b0, 1'b0);
    tick(5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 2'd1, 1'b0, 1'b0);
    checks++;
    if (obs_stall !== 1'b0) begin errors++; $display("FAIL r0_stall got=%b want=0", obs_stall); end
    checks++;
    if (obs_sel !== 4'h0) begin errors++; $display("FAIL r0_sel got=%h want=0", obs_sel); end
  endtask

  task automatic test_hold();
    tick(5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 2'(LAT_LOAD), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(5'd4, 5'd0, 2'b01, 5'd9, 1'b1, 2'd1, 1'b1, 1'b0);
      checks++;
      if (obs_stall !== 1'b0) begin errors++; $display("FAIL hold_stall%0d got=%b want=0", i, obs_stall); end
      checks++;
      if (obs_sel !== exp_sel) begin errors++; $display("FAIL hold_sel%0d got=%h want=%h", i, obs_sel, exp_sel); end
    end
    tick(5'd4, 5'd0, 2'b01, 5'd9, 1'b1, 2'd1, 1'b0, 1'b0);
    checks++;
    if (obs_stall !== 1'b1) begin errors++; $display("FAIL hold_resume_stall got=%b want=1", obs_stall); end
    tick(5'd4, 5'd0, 2'b01, 5'd9, 1'b1, 2'd1, 1'b0, 1'b0);
    checks++;
    if (obs_stall !== 1'b0) begin errors++; $display("FAIL hold_after_stall got=%b want=0", obs_stall); end
    checks++;
    if (obs_sel !== 4'h2) begin errors++; $display("FAIL hold_after_sel got=%h want=2", obs_sel); end
  endtask

  task automatic test_flush();
    tick(5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 2'(LAT_LOAD), 1'b0, 1'b0);
    tick(5'd4, 5'd0, 2'b01, 5'd8, 1'b1, 2'd1, 1'b0, 1'b1);
    checks++;
    if (obs_sel !== 4'h0) begin errors++; $display("FAIL flush_sel got=%h want=0", obs_sel); end
    tick(5'd8, 5'd0, 2'b01, 5'd0, 1'b0, 2'd1, 1'b0, 1'b0);
    checks++;
    if (obs_stall !== 1'b0) begin errors++; $display("FAIL flush_next_stall got=%b want=0", obs_stall); end
    checks++;
    if (obs_sel !== 4'h0) begin errors++; $display("FAIL flush_next_sel got=%h want=0", obs_sel); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [4:0] s0, s1, rd;
      s0 = 5'($urandom_range(0, 7));
      s1 = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      tick(s0, s1, 2'($urandom_range(0, 3)), rd, 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      checks++;
      if (obs_stall !== exp_stall) begin errors++; $display("FAIL rand_stall n=%0d got=%b want=%b", n, obs_stall, exp_stall); end
      checks++;
      if (obs_sel !== exp_sel) begin errors++; $display("FAIL rand_sel n=%0d got=%h want=%h", n, obs_sel, exp_sel); end
    end
  endtask

  task automatic test_param();
    do_reset(1'b0);
    tick4(5'd0, 5'd0, 5'd0, 3'b000, 5'd9, 1'b1, 3'd3);
    for (int i = 0; i < 2; i++) begin
      tick4(5'd0, 5'd0, 5'd9, 3'b100, 5'd0, 1'b0, 3'd1);
      checks++;
      if (obs4_stall !== 1'b1) begin errors++; $display("FAIL mul_stall%0d got=%b want=1", i, obs4_stall); end
    end
    tick4(5'd0, 5'd0, 5'd9, 3'b100, 5'd0, 1'b0, 3'd1);
    checks++;
    if (obs4_stall !== 1'b0) begin errors++; $display("FAIL mul_go_stall got=%b want=0", obs4_stall); end
    checks++;
    if (obs4_sel !== 9'o300) begin errors++; $display("FAIL mul_sel got=%o want=300", obs4_sel); end
    tick4(5'd0, 5'd0, 5'd0, 3'b000, 5'd10, 1'b1, 3'd1);
    for (int i = 0; i < 3; i++) tick4(5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 3'd1);
    tick4(5'd10, 5'd0, 5'd0, 3'b001, 5'd0, 1'b0, 3'd1);
    checks++;
    if (obs4_sel !== 9'o004) begin errors++; $display("FAIL oldest_sel got=%o want=004", obs4_sel); end
    tick4(5'd0, 5'd0, 5'd0, 3'b000, 5'd11, 1'b1, 3'd1);
    for (int i = 0; i < 4; i++) tick4(5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 3'd1);
    tick4(5'd11, 5'd0, 5'd0, 3'b001, 5'd0, 1'b0, 3'd1);
    checks++;
    if (obs4_stall !== 1'b0) begin errors++; $display("FAIL dropped_stall got=%b want=0", obs4_stall); end
    checks++;
    if (obs4_sel !== 9'o000) begin errors++; $display("FAIL dropped_sel got=%o want=000", obs4_sel); end
  endtask

  initial begin
    b3.iID_NumSrc = '0; b3.iID_SrcUsed = '0; b3.iID_NumRd = '0; b3.iID_RegWrite = 1'b0;
    b3.iID_Lat = '0; b3.iHold = 1'b0; b3.iFlush = 1'b0;
    b4.iID_NumSrc = '0; b4.iID_SrcUsed = '0; b4.iID_NumRd = '0; b4.iID_RegWrite = 1'b0;
    b4.iID_Lat = '0; b4.iHold = 1'b0; b4.iFlush = 1'b0;
    model_clear();
    @(posedge clk); #1;
    test_reset();
    test_alu_use();
    test_load_use();
    test_priority();
    test_hold();
    test_flush();
    test_random();
    test_param();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
